// File: rtl/or1200_cl_enc_arb_if.sv
// or1200_cl_enc_arb_if: bus between the pad arbiter and the shared dual-AES pad engine.
interface or1200_cl_enc_arb_if;
    logic         eng_start;
    logic [63:0]  eng_seed;
    logic         eng_done;
    logic [127:0] eng_pad_1;
    logic [127:0] eng_pad_2;
    modport master (output eng_start, eng_seed, input eng_done, eng_pad_1, eng_pad_2);
    modport slave  (input eng_start, eng_seed, output eng_done, eng_pad_1, eng_pad_2);
endinterface

// File: rtl/or1200_cl_enc_arb.sv
// or1200_cl_enc_arb: round-robin arbiter/sequencer for the shared cache-line pad engine.
// Optional single-entry pad reuse store enabled by CL_ENC_PAD_REUSE_EN.
module or1200_cl_enc_arb #(
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                secure_exec,
    input  logic [1:0]          req,
    input  logic [63:0]         seed0,
    input  logic [63:0]         seed1,
    input  logic                key_change,
    output logic [1:0]          rsp_valid,
    output logic                rsp_err,
    output logic                rsp_hit,
    output logic [127:0]        pad_1,
    output logic [127:0]        pad_2,
    output logic                busy,
    or1200_cl_enc_arb_if.master eng
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic grant, last_grant, err_r, win, timeout, hit;
    logic [TO_W-1:0] cnt;
    logic [63:0] win_seed;
    logic [127:0] hit_pad_1, hit_pad_2;

    // a lone request always wins; on a tie the requester not served last wins
    assign win      = (req == 2'b11) ? ~last_grant : req[1];
    assign win_seed = win ? seed1 : seed0;
    assign timeout  = cnt == TO_W'(TIMEOUT_CYC - 1);

    assign eng.eng_start = state == ISSUE;
    assign busy          = state != IDLE;
    assign rsp_valid     = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err       = state == RESP && err_r;

`ifdef CL_ENC_PAD_REUSE_EN
    logic st_valid, hit_r;
    logic [63:0] st_seed;
    logic [127:0] st_pad_1, st_pad_2;
    assign hit       = st_valid && st_seed == win_seed && !key_change;
    assign hit_pad_1 = st_pad_1;
    assign hit_pad_2 = st_pad_2;
    assign rsp_hit   = state == RESP && hit_r;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_valid <= 1'b0;
            st_seed  <= '0;
            st_pad_1 <= '0;
            st_pad_2 <= '0;
            hit_r    <= 1'b0;
        end else begin
            if (state == IDLE && req != 2'b00)
                hit_r <= secure_exec && hit;
            if (key_change || (state == WAIT && !eng.eng_done && timeout))
                st_valid <= 1'b0;
            else if (state == WAIT && eng.eng_done) begin
                st_valid <= 1'b1;
                st_seed  <= eng.eng_seed;
                st_pad_1 <= eng.eng_pad_1;
                st_pad_2 <= eng.eng_pad_2;
            end
        end
    end
`else
    logic unused_key_change;
    assign unused_key_change = key_change;
    assign hit       = 1'b0;
    assign hit_pad_1 = '0;
    assign hit_pad_2 = '0;
    assign rsp_hit   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (req == 2'b00) ? IDLE : (secure_exec && !hit) ? ISSUE : RESP;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (eng.eng_done || timeout) ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            err_r        <= 1'b0;
            eng.eng_seed <= '0;
            pad_1        <= '0;
            pad_2        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req != 2'b00) begin
                grant      <= win;
                last_grant <= win;
                err_r      <= 1'b0;
                if (secure_exec && !hit)
                    eng.eng_seed <= win_seed;
                else begin
                    pad_1 <= secure_exec ? hit_pad_1 : '0;
                    pad_2 <= secure_exec ? hit_pad_2 : '0;
                end
            end
            if (state == ISSUE)
                cnt <= '0;
            // done wins over a timeout landing in the same cycle
            if (state == WAIT) begin
                if (eng.eng_done || timeout) begin
                    err_r <= !eng.eng_done;
                    pad_1 <= eng.eng_done ? eng.eng_pad_1 : '0;
                    pad_2 <= eng.eng_done ? eng.eng_pad_2 : '0;
                end else
                    cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_or1200_cl_enc_arb.sv
// tb_or1200_cl_enc_arb: directed plus randomized transactions checked against a transaction-level model.
module tb_or1200_cl_enc_arb;
    localparam int TOUT = 12;
    logic clk = 1'b0, rst = 1'b0;
    logic sec = 1'b0, kc = 1'b0;
    logic [1:0] req = 2'b00;
    logic [63:0] s0 = '0, s1 = '0;
    logic [1:0] rsp_valid;
    logic rsp_err, rsp_hit, busy;
    logic [127:0] pad_1, pad_2;
    int errs = 0, checks = 0;
    bit m_last = 1'b1;
    bit m_valid = 1'b0;
    logic [63:0] m_seed = '0;
    logic [127:0] m_p1 = '0, m_p2 = '0;

    or1200_cl_enc_arb_if eif();

    or1200_cl_enc_arb #(.TIMEOUT_CYC(TOUT), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .secure_exec(sec), .req(req), .seed0(s0), .seed1(s1),
        .key_change(kc), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_hit(rsp_hit),
        .pad_1(pad_1), .pad_2(pad_2), .busy(busy), .eng(eif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k = WAIT cycle on which the engine completes; k >= TOUT means it never does
    task automatic run(input logic [1:0] r, input logic sc, input int k, input logic kcv,
                       input logic [63:0] a0, input logic [63:0] a1);
        bit w, hit, iss, err;
        int lat;
        logic [63:0] sd;
        logic [127:0] p1, p2, e1, e2;
        @(negedge clk);
        w = (r == 2'b11) ? !m_last : r[1];
        m_last = w;
        sd = w ? a1 : a0;
        hit = 1'b0;
`ifdef CL_ENC_PAD_REUSE_EN
        hit = sc && m_valid && m_seed == sd && !kcv;
        if (kcv) m_valid = 1'b0;
`endif
        iss = sc && !hit;
        err = iss && k >= TOUT;
        lat = !iss ? 1 : err ? 2 + TOUT : 3 + k;
        p1 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        e1 = hit ? m_p1 : (iss && !err) ? p1 : '0;
        e2 = hit ? m_p2 : (iss && !err) ? p2 : '0;
        req = r; s0 = a0; s1 = a1; sec = sc; kc = kcv;
        eif.eng_pad_1 = p1; eif.eng_pad_2 = p2;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            kc = 1'b0;
            eif.eng_done = iss && !err && c == 2 + k;
            chk("eng_start", eif.eng_start, iss && c == 1);
            chk("rsp_valid", rsp_valid, (c == lat) ? (w ? 2'b10 : 2'b01) : 2'b00);
            chk("err_hit", {rsp_err, rsp_hit}, (c == lat) ? {err, hit} : 2'b00);
            chk("busy", busy, 1'b1);
            if (iss && c == 1) chk("eng_seed", eif.eng_seed, sd);
        end
        chk("pad_1", pad_1, e1);
        chk("pad_2", pad_2, e2);
        eif.eng_done = 1'b0;
        req = 2'b00;
        @(negedge clk);
        chk("idle", {busy, rsp_valid, rsp_err, rsp_hit, eif.eng_start}, 6'b0);
        chk("pad_hold", {pad_1, pad_2}, {e1, e2});
`ifdef CL_ENC_PAD_REUSE_EN
        if (iss && !err) begin
            m_valid = 1'b1; m_seed = sd; m_p1 = p1; m_p2 = p2;
        end else if (err) m_valid = 1'b0;
`endif
    endtask

    initial begin
        eif.eng_done = 1'b0;
        eif.eng_pad_1 = '0;
        eif.eng_pad_2 = '0;
        repeat (2) @(negedge clk);
        chk("reset_out", {busy, rsp_valid, rsp_err, rsp_hit, eif.eng_start, pad_1, pad_2, eif.eng_seed}, '0);
        rst = 1'b1;
        run(2'b01, 1'b1, 10, 1'b0, 64'h1, 64'h0);
        run(2'b11, 1'b1, 3, 1'b0, 64'h10, 64'h20);
        run(2'b11, 1'b1, 4, 1'b0, 64'h11, 64'h21);
        run(2'b11, 1'b1, 0, 1'b0, 64'h12, 64'h22);
        run(2'b11, 1'b1, 1, 1'b0, 64'h13, 64'h23);
        run(2'b01, 1'b1, 99, 1'b0, 64'h30, 64'h0);
        run(2'b01, 1'b1, TOUT - 1, 1'b0, 64'h31, 64'h0);
        run(2'b10, 1'b1, 2, 1'b0, 64'h0, 64'h32);
        run(2'b10, 1'b0, 0, 1'b0, 64'h0, 64'h33);
        run(2'b01, 1'b1, 5, 1'b0, 64'h55, 64'h0);
        run(2'b01, 1'b1, 5, 1'b0, 64'h55, 64'h0);
        run(2'b01, 1'b1, 5, 1'b1, 64'h55, 64'h0);
        run(2'b10, 1'b1, 6, 1'b0, 64'h0, 64'h55);
        // reset dropped while the engine is still working
        @(negedge clk);
        req = 2'b01; sec = 1'b1; s0 = 64'h77;
        repeat (3) @(negedge clk);
        rst = 1'b0; req = 2'b00;
        #1 chk("rst_wait", {busy, rsp_valid, rsp_err, rsp_hit, eif.eng_start, pad_1, pad_2, eif.eng_seed}, '0);
        m_last = 1'b1; m_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; eif.eng_done = 1'b1;
        @(negedge clk);
        eif.eng_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_late_done", {busy, rsp_valid, rsp_err, eif.eng_start}, 5'b0);
            @(negedge clk);
        end
        run(2'b11, 1'b1, 2, 1'b0, 64'h40, 64'h41);
        for (int i = 0; i < 40; i++) begin
            logic [63:0] a0, a1;
            a0 = ($urandom_range(0, 2) == 0) ? 64'h55 : {$urandom, $urandom};
            a1 = ($urandom_range(0, 2) == 0) ? 64'h55 : {$urandom, $urandom};
            run(2'($urandom_range(1, 3)), $urandom_range(0, 4) != 0, $urandom_range(0, TOUT + 3),
                $urandom_range(0, 7) == 0, a0, a1);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
